// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART byte-stream boot loader into instruction memory
//
// Accepts a length-prefixed, checksummed program image one byte at a time and
// writes it into instruction memory as little-endian 32-bit words while
// holding the CPU in reset.
//
// Image format: N[7:0] N[15:8] | 4*N data bytes | 8-bit sum of data bytes
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   start      - one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid - byte_data valid this cycle
//   byte_data  - received byte
//   wr_en      - one-cycle instruction-memory write strobe
//   wr_addr    - word address of the write (held until next write)
//   wr_data    - instruction word of the write (held until next write)
//   cpu_hold   - keeps the CPU in reset while high
//   done       - sticky: image loaded and checksum matched
//   error      - sticky: load aborted (oversize, checksum, timeout)
module prog_loader #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    // Largest legal word count; the compare is done one bit wider than N so
    // that ADDR_W = 16 still works.
    localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [15:0]     word_cnt;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_word;   // first three bytes of the word in flight
    logic [7:0]      csum;
    logic [TO_W-1:0] to_cnt;

    logic [15:0] n_rx;
    assign n_rx = {byte_data, len_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            len_lo   <= '0;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            csum     <= '0;
            to_cnt   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    // byte_valid is ignored here, including alongside start
                    if (start) begin
                        state    <= LEN_LO;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        csum     <= '0;
                        to_cnt   <= '0;
                    end
                end
                default: begin
                    if (byte_valid) begin
                        to_cnt <= '0;
                        case (state)
                            LEN_LO: begin
                                len_lo <= byte_data;
                                state  <= LEN_HI;
                            end
                            LEN_HI: begin
                                len <= n_rx;
                                if (n_rx == 16'd0) begin
                                    state <= CSUM;
                                end else if ({1'b0, n_rx} > MAX_WORDS) begin
                                    state <= ERR;
                                    error <= 1'b1;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                csum     <= csum + byte_data;
                                byte_cnt <= byte_cnt + 2'd1;
                                asm_word <= {byte_data, asm_word[23:8]};
                                if (byte_cnt == 2'd3) begin
                                    wr_en    <= 1'b1;
                                    wr_addr  <= ADDR_W'(word_cnt);
                                    wr_data  <= {byte_data, asm_word};
                                    word_cnt <= word_cnt + 16'd1;
                                    // len >= 1 here, so len - 1 cannot wrap
                                    if (word_cnt == len - 16'd1) begin
                                        state <= CSUM;
                                    end
                                end
                            end
                            CSUM: begin
                                if (byte_data == csum) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end else begin
                                    state <= ERR;
                                    error <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        // TIMEOUT_CYC consecutive idle cycles
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;

    // write log filled by the monitor
    int          wr_cnt = 0;
    logic [13:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    int          base;

    prog_loader #(.ADDR_W(14), .TIMEOUT_CYC(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr[wr_cnt & 63] = wr_addr;
            log_data[wr_cnt & 63] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // all drive tasks start and end on a falling edge
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_image(input logic [7:0] cs);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(cs);
    endtask

    initial begin
        // reset state
        idle(2);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b0;
        idle(1);

        // normal load
        base = wr_cnt;
        do_start();
        chk("norm_hold_start", cpu_hold, 1);
        send_image(8'hB6);
        idle(1);
        chk("norm_wr_count", wr_cnt - base, 2);
        chk("norm_addr0", log_addr[base & 63], 0);
        chk("norm_data0", log_data[base & 63], 32'h00000013);
        chk("norm_addr1", log_addr[(base + 1) & 63], 1);
        chk("norm_data1", log_data[(base + 1) & 63], 32'h00100093);
        chk("norm_done", done, 1);
        chk("norm_error", error, 0);
        chk("norm_hold", cpu_hold, 0);
        chk("norm_addr_held", wr_addr, 1);
        chk("norm_data_held", wr_data, 32'h00100093);

        // bad checksum
        base = wr_cnt;
        do_start();
        chk("bad_done_cleared", done, 0);
        send_image(8'h00);
        idle(1);
        chk("bad_wr_count", wr_cnt - base, 2);
        chk("bad_data1", log_data[(base + 1) & 63], 32'h00100093);
        chk("bad_error", error, 1);
        chk("bad_done", done, 0);
        chk("bad_hold", cpu_hold, 1);

        // empty image; byte_valid alongside start must be ignored
        base = wr_cnt;
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h05;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;
        chk("empty_error_cleared", error, 0);
        send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        chk("empty_wr_count", wr_cnt - base, 0);
        chk("empty_done", done, 1);
        chk("empty_hold", cpu_hold, 0);

        // byte_valid in DONE is ignored
        send(8'h11); send(8'h22);
        chk("done_ignore_bytes", {done, error, cpu_hold}, 3'b100);

        // oversize image N = 16385
        base = wr_cnt;
        do_start();
        send(8'h01); send(8'h40);
        chk("over_error", error, 1);
        chk("over_hold", cpu_hold, 1);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        chk("over_wr_count", wr_cnt - base, 0);

        // N = 16384 is legal; then timeout after 3 data bytes
        base = wr_cnt;
        do_start();
        send(8'h00); send(8'h40);
        chk("max_len_no_error", error, 0);
        send(8'h13); send(8'h00); send(8'h00);
        idle(90);
        chk("to_not_yet", error, 0);
        idle(15);
        chk("to_error", error, 1);
        chk("to_hold", cpu_hold, 1);
        chk("to_wr_count", wr_cnt - base, 0);

        // reset mid-DATA, then restart
        base = wr_cnt;
        do_start();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00);
        chk("mid_wr_count", wr_cnt - base, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {wr_en, cpu_hold, done, error}, 4'b0000);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        @(negedge clk);
        reset = 1'b0;
        base = wr_cnt;
        send(8'h10); send(8'h00);
        idle(2);
        chk("mid_no_write_after_rst", wr_cnt - base, 0);
        chk("mid_idle_hold", cpu_hold, 0);
        do_start();
        send_image(8'hB6);
        idle(1);
        chk("re_wr_count", wr_cnt - base, 2);
        chk("re_addr0", log_addr[base & 63], 0);
        chk("re_data0", log_data[base & 63], 32'h00000013);
        chk("re_addr1", log_addr[(base + 1) & 63], 1);
        chk("re_done", done, 1);
        chk("re_hold", cpu_hold, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
